// File: rtl/fmap_stream_packer_pkg.sv
// Shared definitions for the conv2d input-side frame packer: default geometry, FSM states, slot placement.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package fmap_stream_packer_pkg;

    // Default geometry, matching the conv2d input feature map.
    localparam int DEF_IN_H   = 5;
    localparam int DEF_IN_W   = 5;
    localparam int DEF_DATA_W = 8;

    // Packer FSM states; the encoding is shared with conv2d-side tooling.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    // MSB of pixel slot k in a flat frame of npix pixels. Pixel 0 occupies the top bits,
    // so the consumer and the future output unpacker index the frame the same way.
    function automatic int slot_msb(input int k, input int npix, input int data_w);
        return (npix - k) * data_w - 1;
    endfunction

    // Width of the pixel counter. A one-pixel frame still gets a 1-bit counter.
    function automatic int cnt_width(input int npix);
        return (npix > 1) ? $clog2(npix) : 1;
    endfunction

endpackage

// File: rtl/fmap_stream_packer_if.sv
// Pixel-stream in / flat-frame out bus bundle for the frame packer.
// Latency: n/a (wires only).
// Backpressure: pixel side valid/ready per beat; frame side valid/ready per whole frame.
interface fmap_stream_packer_if #(
    parameter int IN_H   = 5,
    parameter int IN_W   = 5,
    parameter int DATA_W = 8
) ();

    localparam int NPIX = IN_H * IN_W;

    // Pixel stream from the source.
    logic                   s_valid;
    logic                   s_ready;
    logic [DATA_W-1:0]      s_data;
    logic                   s_last;

    // Assembled frame towards conv2d.
    logic                   m_valid;
    logic                   m_ready;
    logic [NPIX*DATA_W-1:0] m_frame;

    // Frame-length error pulse.
    logic                   err;

    // Packer side: consumes pixels, produces the frame.
    modport master (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_frame, err
    );

    // Environment side: pixel source plus frame consumer.
    modport slave (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_frame, err
    );

endinterface

// File: rtl/fmap_stream_packer.sv
// Packs a row-major pixel stream into one flat IN_H x IN_W frame for conv2d (pixel 0 in MSBs).
// Latency: m_valid rises the cycle after the final pixel handshake; one bubble cycle per frame.
// Backpressure: s_ready low while a full frame waits; m_valid held until m_ready. Option: FMAP_PACKER_TLAST_EN.
module fmap_stream_packer
    import fmap_stream_packer_pkg::*;
#(
    parameter int IN_H   = DEF_IN_H,
    parameter int IN_W   = DEF_IN_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    fmap_stream_packer_if.master  bus
);

    localparam int NPIX  = IN_H * IN_W;
    localparam int CNT_W = cnt_width(NPIX);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NPIX - 1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              wr_en;
    logic              s_ready_c;
    logic              m_valid_c;
    logic [DATA_W-1:0] pix_q [NPIX];
    logic [NPIX*DATA_W-1:0] frame_flat;

`ifdef FMAP_PACKER_TLAST_EN
    logic              err_d;
    logic              err_q;
`endif

    // State and slot counter; reset drops any partial frame and restarts at slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state, counter advance and handshake outputs. The counter only returns to 0
    // through the last-slot compare (or an early s_last), never by wrapping on its own.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_en     = 1'b0;
        s_ready_c = 1'b0;
        m_valid_c = 1'b0;
`ifdef FMAP_PACKER_TLAST_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            ST_FILL: begin
                s_ready_c = 1'b1;
                if (bus.s_valid) begin
                    wr_en = 1'b1;
                    if (count_q == LAST_SLOT) begin
                        count_d = '0;
                        state_d = ST_FULL;
`ifdef FMAP_PACKER_TLAST_EN
                        // Frame completes by count anyway; a missing end marker is only flagged.
                        err_d   = !bus.s_last;
`endif
                    end
`ifdef FMAP_PACKER_TLAST_EN
                    else if (bus.s_last) begin
                        // Short frame: the pixel is written but the frame is abandoned.
                        count_d = '0;
                        err_d   = 1'b1;
                    end
`endif
                    else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_FULL: begin
                m_valid_c = 1'b1;
                if (bus.m_ready) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Pixel slots; never cleared between frames because every slot is rewritten before m_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NPIX; k++) begin
                pix_q[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < NPIX; k++) begin
                if (count_q == CNT_W'(k)) begin
                    pix_q[k] <= bus.s_data;
                end
            end
        end
    end

    // Flatten: slot k lands at bits [(NPIX-k)*DATA_W-1 -: DATA_W].
    for (genvar k = 0; k < NPIX; k++) begin : g_pack
        assign frame_flat[slot_msb(k, NPIX, DATA_W) -: DATA_W] = pix_q[k];
    end

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_c;
    assign bus.m_frame = frame_flat;

`ifdef FMAP_PACKER_TLAST_EN
    // One-cycle error pulse, registered so it follows the offending beat by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    // Framing is by count only; the end marker is not looked at.
    logic unused_s_last;
    assign unused_s_last = bus.s_last;
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_fmap_stream_packer.sv
// Self-checking bench for fmap_stream_packer: random pixel source, frame scoreboard, protocol checks.
// Latency: checks m_valid on the cycle after the final pixel beat.
// Backpressure: m_ready driven always-on, held off, or random.
module tb_fmap_stream_packer;
    import fmap_stream_packer_pkg::*;

    localparam int IN_H   = 5;
    localparam int IN_W   = 5;
    localparam int DATA_W = 8;
    localparam int NPIX   = IN_H * IN_W;
    localparam int FW     = NPIX * DATA_W;

`ifdef FMAP_PACKER_TLAST_EN
    localparam int SHORT_N = 10;
`else
    localparam int SHORT_N = NPIX;
`endif

    typedef logic [FW-1:0] frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fmap_stream_packer_if #(.IN_H(IN_H), .IN_W(IN_W), .DATA_W(DATA_W)) bus ();

    fmap_stream_packer #(.IN_H(IN_H), .IN_W(IN_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: pixels of the frame being assembled, frames owed to the consumer.
    logic [DATA_W-1:0] cur_px[$];
    frame_t            exp_q[$];
    frame_t            f_build;
    int                frames_exp = 0;
    int                frames_seen = 0;
    bit                err_exp = 1'b0;
    bit                valid_due = 1'b0;
    bit                prev_valid = 1'b0;
    bit                prev_ready = 1'b0;
    int                rdy_mode = 0;

    task automatic chk(input bit ok, input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Consumer readiness: 0 = always ready, 1 = stalled, 2 = random.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = 1'b0;
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor and scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            cur_px.delete();
            exp_q.delete();
            err_exp    = 1'b0;
            valid_due  = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            chk(bus.err === err_exp, "err", bus.err, err_exp);
            chk(bus.s_ready === !bus.m_valid, "s_ready_excl", bus.s_ready, !bus.m_valid);
            if (valid_due)
                chk(bus.m_valid === 1'b1, "latency", bus.m_valid, 1);
            if (prev_valid && !prev_ready)
                chk(bus.m_valid === 1'b1, "valid_hold", bus.m_valid, 1);
            if (prev_valid && prev_ready)
                chk(bus.m_valid === 1'b0 && bus.s_ready === 1'b1, "bubble", {bus.m_valid, bus.s_ready}, 2'b01);
            if (bus.m_valid === 1'b1) begin
                chk(exp_q.size() > 0, "frame_owed", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    chk(bus.m_frame === exp_q[0], "frame", bus.m_frame, exp_q[0]);
                    if (bus.m_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                        frames_seen++;
                    end
                end
            end

            err_exp   = 1'b0;
            valid_due = 1'b0;
            if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) begin
                cur_px.push_back(bus.s_data);
                if (cur_px.size() == NPIX) begin
                    f_build = '0;
                    foreach (cur_px[i]) f_build = (f_build << DATA_W) | frame_t'(cur_px[i]);
                    exp_q.push_back(f_build);
                    frames_exp++;
                    valid_due = 1'b1;
`ifdef FMAP_PACKER_TLAST_EN
                    err_exp = !bus.s_last;
`endif
                    cur_px.delete();
                end
`ifdef FMAP_PACKER_TLAST_EN
                else if (bus.s_last === 1'b1) begin
                    cur_px.delete();
                    err_exp = 1'b1;
                end
`endif
            end
            prev_valid = (bus.m_valid === 1'b1);
            prev_ready = (bus.m_ready === 1'b1);
        end
    end

    // Source: n pixels base+k (or random), s_last on last_idx, random idle gaps up to gap_max.
    task automatic send_frame(input int base, input int gap_max, input int last_idx, input bit rnd, input int n);
        for (int k = 0; k < n; k++) begin
            int gap;
            bit acc;
            int tries;
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (gap > 0) begin
                bus.s_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.s_valid = 1'b1;
            bus.s_data  = rnd ? DATA_W'($urandom) : DATA_W'(base + k);
            bus.s_last  = (k == last_idx);
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 300) begin
                @(negedge clk);
                acc = (bus.s_ready === 1'b1);
                @(posedge clk);
                #1;
                tries++;
            end
            chk(acc, "accept_timeout", tries, 300);
        end
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk(bus.s_ready === 1'b1, "rst_s_ready", bus.s_ready, 1);
        chk(bus.m_valid === 1'b0, "rst_m_valid", bus.m_valid, 0);
        chk(bus.err === 1'b0, "rst_err", bus.err, 0);
        chk(bus.m_frame === '0, "rst_m_frame", bus.m_frame, 0);
        @(posedge clk);
        #1;

        // Single frame 1..25, consumer always ready.
        rdy_mode = 0;
        send_frame(1, 0, NPIX - 1, 1'b0, NPIX);
        idle();
        drain();

        // Consumer stalls; source holds the first pixel of the next frame meanwhile.
        rdy_mode = 1;
        send_frame(1, 0, NPIX - 1, 1'b0, NPIX);
        fork
            send_frame(201, 0, NPIX - 1, 1'b0, NPIX);
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk(bus.m_valid === 1'b1, "stall_m_valid", bus.m_valid, 1);
                    chk(bus.s_ready === 1'b0, "stall_s_ready", bus.s_ready, 0);
                end
                @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        join
        idle();
        drain();

        // Back-to-back frames with s_valid never dropping.
        send_frame(1, 0, NPIX - 1, 1'b0, NPIX);
        send_frame(101, 0, NPIX - 1, 1'b0, NPIX);
        idle();
        drain();

        // Random gaps, random data, random consumer readiness.
        rdy_mode = 2;
        repeat (6) send_frame(0, 3, NPIX - 1, 1'b1, NPIX);
        idle();
        @(posedge clk);
        #1;
        rdy_mode = 0;
        drain();

        // Reset after 12 pixels, then a full fresh frame.
        send_frame(1, 0, NPIX - 1, 1'b0, 12);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(bus.s_ready === 1'b1, "midrst_s_ready", bus.s_ready, 1);
        chk(bus.m_valid === 1'b0, "midrst_m_valid", bus.m_valid, 0);
        chk(bus.m_frame === '0, "midrst_m_frame", bus.m_frame, 0);
        @(posedge clk);
        #1;
        send_frame(1, 0, NPIX - 1, 1'b0, NPIX);
        idle();
        drain();

        // End marker on pixel 10, then a correctly framed frame.
        send_frame(1, 0, 9, 1'b0, SHORT_N);
        idle();
        repeat (2) @(posedge clk);
        #1;
        send_frame(51, 0, NPIX - 1, 1'b0, NPIX);
        idle();
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk(frames_seen == frames_exp, "frame_count", frames_seen, frames_exp);
        chk(cur_px.size() == 0, "leftover_pixels", cur_px.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
